axis_fifo: RTL and testbench
============================

AXIS_FIFO -- requirements
Module: axis_fifo

Interface
REQ-001 The module SHALL have parameter DEPTH, default 16, giving the number of beats stored; it must be a power of two, at least 2.
REQ-002 The module SHALL have parameter TKEEP_ENABLE, default 1'b1; when 0, stored tkeep is ignored and m_axis.tkeep is driven all-ones.
REQ-003 The module SHALL have port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-005 The module SHALL have port s_axis, AXIS_IF.Slave modport: the input stream.
REQ-006 The module SHALL have port m_axis, AXIS_IF.Master modport: the output stream.
REQ-007 The module SHALL have port count, output, width $clog2(DEPTH)+1: beats currently stored.
REQ-008 The module SHALL have port full, output, width 1: high when count == DEPTH.
REQ-009 The module SHALL have port empty, output, width 1: high when count == 0.

Function
REQ-010 Each accepted beat SHALL store all sideband fields: tdata, tstrb, tkeep, tlast, tid, tdest, tuser and twakeup.
REQ-011 Output order SHALL be strict FIFO, with no reordering, duplication or loss.
REQ-012 A beat SHALL be accepted when s_axis.tvalid && s_axis.tready, and SHALL leave when m_axis.tvalid && m_axis.tready.
REQ-013 s_axis.tready SHALL equal !full, registered and independent of m_axis.tready in the same cycle; there is no combinational ready path.
REQ-014 The output SHALL be first-word-fall-through: m_axis.tvalid is high exactly when count != 0, and m_axis data is the oldest beat.
REQ-015 Latency SHALL be one cycle: a beat accepted into an empty FIFO in cycle N is presented on m_axis in cycle N+1.
REQ-016 Once m_axis.tvalid is high, the output beat and tvalid SHALL stay stable until the beat is accepted (AXIS rule).
REQ-017 On a simultaneous write and read, count SHALL be unchanged; the pointers wrap modulo DEPTH.
REQ-018 When full, writes SHALL be blocked even if a read occurs in the same cycle; s_axis.tready rises in the cycle after that read.
REQ-019 When empty, m_axis.tvalid SHALL be 0; an incoming write SHALL not be forwarded in the same cycle.
REQ-020 Pointers SHALL be $clog2(DEPTH) bits wide and count SHALL be $clog2(DEPTH)+1 bits wide; full and empty are decoded from count.
REQ-021 Elaboration SHALL fail if the s_axis and m_axis parameters (TDATA_WIDTH, TID_WIDTH, TDEST_WIDTH, TUSER_WIDTH) differ, or if DEPTH is not a power of two.
REQ-022 The bench SHALL assert, and the design SHALL never produce, an overflow (write while full) or an underflow (read while empty).

Reset
REQ-023 While rst is high, count SHALL be 0, both pointers 0, empty 1, full 0, m_axis.tvalid 0 and s_axis.tready 0.
REQ-024 s_axis.tready SHALL rise in the first cycle after rst deasserts.
REQ-025 Reset asserted mid-operation SHALL discard all stored beats within one cycle, with no beat emitted after reset.
REQ-026 Storage memory contents SHALL NOT be reset; only control state is reset.

Structure
REQ-027 The beat-packing helper (the total stored width as a function of the interface parameters) and the DEPTH legality check SHALL live in the shared package axis_pkg.
REQ-028 Storage SHALL be a sub-module axis_fifo_ram: simple dual-port, one write port, one asynchronous read port, width equal to the packed beat width, DEPTH entries.
REQ-029 Control (pointers, count, handshakes) SHALL stay in axis_fifo.

Verification
REQ-030 Reset then a single beat: after reset, write tdata=0xA5 with tlast=1 in cycle 5 -> m_axis.tvalid=1 in cycle 6 with tdata=0xA5, tlast=1; count=1 then 0 after the read.
REQ-031 Fill to full: DEPTH=16, m_axis.tready=0, write 0..15 -> full=1, s_axis.tready=0, count=16; a 17th beat held on the input is not accepted.
REQ-032 Full plus a simultaneous read: on a read with the 17th beat offered, that beat is not accepted in the same cycle; it is accepted in the next cycle; count goes 16->15->16.
REQ-033 Wrap-around streaming: 100 beats of incrementing data (with tid, tdest, tuser randomised) under random tready on both sides -> output matches a scoreboard exactly, and pointers wrap at least 6 times.
REQ-034 Reset mid-stream: with count=7, assert rst for 1 cycle -> count=0, m_axis.tvalid=0 in the reset cycle and after; the next write of 0x3C is the first beat out.
REQ-035 TKEEP_ENABLE=0: write a beat with tkeep=0 -> m_axis.tkeep is all-ones.

Source files
------------

// File: rtl/axis_pkg.sv
// axis_pkg: shared helpers for the AXI-Stream FIFO.
//   keep_width     - tstrb/tkeep width for a given tdata width
//   beat_width     - total packed width of one stored beat
//   depth_is_legal - DEPTH must be a power of two and at least 2
package axis_pkg;

  function automatic int unsigned keep_width(input int unsigned data_w);
    return (data_w + 7) / 8;
  endfunction

  // Packed beat layout (MSB to LSB):
  // tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup
  function automatic int unsigned beat_width(input int unsigned data_w,
                                             input int unsigned id_w,
                                             input int unsigned dest_w,
                                             input int unsigned user_w);
    return data_w + 2 * keep_width(data_w) + 1 + id_w + dest_w + user_w + 1;
  endfunction

  function automatic bit depth_is_legal(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXIS_IF: AXI-Stream bundle.
//   Master modport drives tvalid and the payload and samples tready.
//   Slave modport samples tvalid and the payload and drives tready.
interface AXIS_IF #(
  parameter int unsigned TDATA_WIDTH = 8,
  parameter int unsigned TID_WIDTH   = 8,
  parameter int unsigned TDEST_WIDTH = 4,
  parameter int unsigned TUSER_WIDTH = 1
);
  localparam int unsigned TKEEP_WIDTH = axis_pkg::keep_width(TDATA_WIDTH);

  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic [TKEEP_WIDTH-1:0] tstrb;
  logic [TKEEP_WIDTH-1:0] tkeep;
  logic                   tlast;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   twakeup;

  modport Master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
    input  tready
  );

  modport Slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
    output tready
  );

endinterface

// File: rtl/axis_fifo_ram.sv
// axis_fifo_ram: simple dual-port storage, one synchronous write port and
// one asynchronous read port. Contents are never reset.
//   i_clk     - write clock
//   i_wr_en   - write strobe
//   i_wr_addr - write address
//   i_wr_data - write data
//   i_rd_addr - read address
//   o_rd_data - read data (combinational from i_rd_addr)
module axis_fifo_ram #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/axis_fifo.sv
// axis_fifo: first-word-fall-through AXI-Stream FIFO.
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   s_axis - input stream (all sideband fields stored)
//   m_axis - output stream, oldest beat presented while count != 0
//   count  - beats currently stored
//   full   - count == DEPTH
//   empty  - count == 0
module axis_fifo
  import axis_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter bit          TKEEP_ENABLE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  AXIS_IF.Slave                  s_axis,
  AXIS_IF.Master                 m_axis,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned DataW = s_axis.TDATA_WIDTH;
  localparam int unsigned IdW   = s_axis.TID_WIDTH;
  localparam int unsigned DestW = s_axis.TDEST_WIDTH;
  localparam int unsigned UserW = s_axis.TUSER_WIDTH;
  localparam int unsigned KeepW = keep_width(DataW);
  localparam int unsigned BeatW = beat_width(DataW, IdW, DestW, UserW);

  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  if (!depth_is_legal(DEPTH)) begin : g_bad_depth
    $error("axis_fifo: DEPTH must be a power of two and at least 2");
  end

  if ((s_axis.TDATA_WIDTH != m_axis.TDATA_WIDTH) ||
      (s_axis.TID_WIDTH   != m_axis.TID_WIDTH)   ||
      (s_axis.TDEST_WIDTH != m_axis.TDEST_WIDTH) ||
      (s_axis.TUSER_WIDTH != m_axis.TUSER_WIDTH)) begin : g_bad_if
    $error("axis_fifo: s_axis and m_axis parameters differ");
  end

  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;
  logic [PtrW:0]    w_count_d;
  logic             r_s_ready;
  logic             w_s_ready_d;
  logic             w_wr;
  logic             w_rd;
  logic [BeatW-1:0] w_wr_beat;
  logic [BeatW-1:0] w_rd_beat;

  logic [DataW-1:0] w_rd_data;
  logic [KeepW-1:0] w_rd_strb;
  logic [KeepW-1:0] w_rd_keep;
  logic             w_rd_last;
  logic [IdW-1:0]   w_rd_id;
  logic [DestW-1:0] w_rd_dest;
  logic [UserW-1:0] w_rd_user;
  logic             w_rd_wakeup;

  // Status is forced to the reset view while rst is high so that nothing
  // is offered or accepted in the reset cycle itself.
  assign count = rst ? '0 : r_count;
  assign full  = (count == FullCount);
  assign empty = (count == '0);

  // tready comes from a flop holding "not full next cycle"; m_axis.tready
  // never reaches it combinationally.
  assign s_axis.tready = r_s_ready & ~rst;
  assign m_axis.tvalid = ~empty;

  assign w_wr = s_axis.tvalid & s_axis.tready;
  assign w_rd = m_axis.tvalid & m_axis.tready;

  always_comb begin
    w_count_d = r_count;
    unique case ({w_wr, w_rd})
      2'b10:   w_count_d = r_count + 1'b1;
      2'b01:   w_count_d = r_count - 1'b1;
      default: w_count_d = r_count;
    endcase
  end

  assign w_s_ready_d = (w_count_d != FullCount);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_s_ready <= 1'b1;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so they wrap naturally.
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count   <= w_count_d;
      r_s_ready <= w_s_ready_d;
    end
  end

  assign w_wr_beat = {s_axis.tdata, s_axis.tstrb, s_axis.tkeep, s_axis.tlast,
                      s_axis.tid, s_axis.tdest, s_axis.tuser, s_axis.twakeup};

  axis_fifo_ram #(
    .WIDTH (BeatW),
    .DEPTH (DEPTH),
    .ADDR_W(PtrW)
  ) u_ram (
    .i_clk    (clk),
    .i_wr_en  (w_wr),
    .i_wr_addr(r_wr_ptr),
    .i_wr_data(w_wr_beat),
    .i_rd_addr(r_rd_ptr),
    .o_rd_data(w_rd_beat)
  );

  assign {w_rd_data, w_rd_strb, w_rd_keep, w_rd_last,
          w_rd_id, w_rd_dest, w_rd_user, w_rd_wakeup} = w_rd_beat;

  assign m_axis.tdata   = w_rd_data;
  assign m_axis.tstrb   = w_rd_strb;
  assign m_axis.tkeep   = TKEEP_ENABLE ? w_rd_keep : '1;
  assign m_axis.tlast   = w_rd_last;
  assign m_axis.tid     = w_rd_id;
  assign m_axis.tdest   = w_rd_dest;
  assign m_axis.tuser   = w_rd_user;
  assign m_axis.twakeup = w_rd_wakeup;

endmodule

// File: tb/tb_axis_fifo.sv
module tb_axis_fifo;

  localparam int unsigned Depth = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  AXIS_IF #(.TDATA_WIDTH(8), .TID_WIDTH(4), .TDEST_WIDTH(3), .TUSER_WIDTH(2)) s_if ();
  AXIS_IF #(.TDATA_WIDTH(8), .TID_WIDTH(4), .TDEST_WIDTH(3), .TUSER_WIDTH(2)) m_if ();
  AXIS_IF #(.TDATA_WIDTH(16), .TID_WIDTH(2), .TDEST_WIDTH(2), .TUSER_WIDTH(1)) s2_if ();
  AXIS_IF #(.TDATA_WIDTH(16), .TID_WIDTH(2), .TDEST_WIDTH(2), .TUSER_WIDTH(1)) m2_if ();

  logic [4:0] count;
  logic       full;
  logic       empty;
  logic [2:0] count2;
  logic       full2;
  logic       empty2;

  axis_fifo #(.DEPTH(Depth), .TKEEP_ENABLE(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .s_axis(s_if),
    .m_axis(m_if),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  axis_fifo #(.DEPTH(4), .TKEEP_ENABLE(1'b0)) dut_nokeep (
    .clk   (clk),
    .rst   (rst),
    .s_axis(s2_if),
    .m_axis(m2_if),
    .count (count2),
    .full  (full2),
    .empty (empty2)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       strb;
    logic       keep;
    logic       last;
    logic [3:0] id;
    logic [2:0] dest;
    logic [1:0] user;
    logic       wake;
  } beat_t;

  typedef struct {
    logic       s_valid;
    logic [7:0] data;
    logic       last;
    logic       m_ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_last;
    logic [4:0] exp_count;
    logic       exp_ready;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_s(input logic v, input logic [7:0] d, input logic last);
    s_if.tvalid  = v;
    s_if.tdata   = d;
    s_if.tlast   = last;
    s_if.tstrb   = 1'b1;
    s_if.tkeep   = 1'b1;
    s_if.tid     = '0;
    s_if.tdest   = '0;
    s_if.tuser   = '0;
    s_if.twakeup = 1'b0;
  endtask

  // Overflow / underflow watch on the main instance.
  always @(posedge clk) begin
    if (rst === 1'b0) begin
      if (s_if.tvalid && s_if.tready && full) begin
        n_err++;
        $display("FAIL overflow: write accepted while full at %0t", $time);
      end
      if (m_if.tvalid && m_if.tready && empty) begin
        n_err++;
        $display("FAIL underflow: read taken while empty at %0t", $time);
      end
    end
  end

  initial begin
    beat_t q[$];
    beat_t cur;
    beat_t act;
    logic  cur_valid;
    logic  exp_valid;
    logic  exp_ready;
    int    sent;
    int    dut_out;
    int    cyc;

    rst = 1'b1;
    drive_s(1'b0, 8'h00, 1'b0);
    m_if.tready   = 1'b0;
    s2_if.tvalid  = 1'b0;
    s2_if.tdata   = '0;
    s2_if.tstrb   = '0;
    s2_if.tkeep   = '0;
    s2_if.tlast   = 1'b0;
    s2_if.tid     = '0;
    s2_if.tdest   = '0;
    s2_if.tuser   = '0;
    s2_if.twakeup = 1'b0;
    m2_if.tready  = 1'b0;

    // s_valid, data, last, m_ready | exp_valid, exp_data, exp_last, exp_count, exp_ready
    tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1};
    tbl[1] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 5'd1, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 5'd1, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1};
    tbl[5] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1};
    tbl[6] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 5'd1, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 5'd1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1};

    // Reset state
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_tready", 32'(s_if.tready), 32'd0);

    // Table-driven single-beat and simultaneous read/write vectors
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive_s(tbl[i].s_valid, tbl[i].data, tbl[i].last);
      m_if.tready = tbl[i].m_ready;
      @(negedge clk);
      check($sformatf("tbl%0d_tvalid", i), 32'(m_if.tvalid), 32'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
      check($sformatf("tbl%0d_tready", i), 32'(s_if.tready), 32'(tbl[i].exp_ready));
      check($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].exp_count == 5'd0));
      if (tbl[i].exp_valid) begin
        check($sformatf("tbl%0d_tdata", i), 32'(m_if.tdata), 32'(tbl[i].exp_data));
        check($sformatf("tbl%0d_tlast", i), 32'(m_if.tlast), 32'(tbl[i].exp_last));
      end
      next_cycle();
    end

    // Fill to full, then a 17th beat held on the input
    drive_s(1'b0, 8'h00, 1'b0);
    m_if.tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive_s(1'b1, 8'(i), 1'b0);
      next_cycle();
    end
    drive_s(1'b1, 8'd16, 1'b1);
    @(negedge clk);
    check("fill_full", 32'(full), 32'd1);
    check("fill_tready", 32'(s_if.tready), 32'd0);
    check("fill_count", 32'(count), 32'd16);
    next_cycle();
    @(negedge clk);
    check("fill_hold_count", 32'(count), 32'd16);
    next_cycle();
    m_if.tready = 1'b1;
    @(negedge clk);
    check("fullrd_count_a", 32'(count), 32'd16);
    check("fullrd_tready_a", 32'(s_if.tready), 32'd0);
    check("fullrd_head_a", 32'(m_if.tdata), 32'd0);
    next_cycle();
    m_if.tready = 1'b0;
    @(negedge clk);
    check("fullrd_count_b", 32'(count), 32'd15);
    check("fullrd_tready_b", 32'(s_if.tready), 32'd1);
    check("fullrd_head_b", 32'(m_if.tdata), 32'd1);
    next_cycle();
    drive_s(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("fullrd_count_c", 32'(count), 32'd16);
    check("fullrd_full_c", 32'(full), 32'd1);
    next_cycle();
    m_if.tready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check($sformatf("drain%0d_tvalid", i), 32'(m_if.tvalid), 32'd1);
      check($sformatf("drain%0d_tdata", i), 32'(m_if.tdata), 32'(i));
      check($sformatf("drain%0d_tlast", i), 32'(m_if.tlast), 32'(i == 16));
      next_cycle();
    end
    m_if.tready = 1'b0;
    @(negedge clk);
    check("drain_empty", 32'(empty), 32'd1);

    // Reset mid-stream with seven beats stored
    next_cycle();
    for (int i = 0; i < 7; i++) begin
      drive_s(1'b1, 8'(8'h40 + i), 1'b0);
      next_cycle();
    end
    drive_s(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("midrst_pre_count", 32'(count), 32'd7);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_tvalid", 32'(m_if.tvalid), 32'd0);
    check("midrst_tready", 32'(s_if.tready), 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("postrst_count", 32'(count), 32'd0);
    check("postrst_tvalid", 32'(m_if.tvalid), 32'd0);
    check("postrst_tready", 32'(s_if.tready), 32'd1);
    next_cycle();
    drive_s(1'b1, 8'h3C, 1'b1);
    next_cycle();
    drive_s(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("postrst_first_tvalid", 32'(m_if.tvalid), 32'd1);
    check("postrst_first_tdata", 32'(m_if.tdata), 32'h3C);
    check("postrst_first_count", 32'(count), 32'd1);
    next_cycle();
    m_if.tready = 1'b1;
    next_cycle();
    m_if.tready = 1'b0;
    @(negedge clk);
    check("postrst_drained", 32'(empty), 32'd1);

    // TKEEP_ENABLE=0 instance: stored tkeep ignored
    next_cycle();
    s2_if.tvalid = 1'b1;
    s2_if.tdata  = 16'hBEEF;
    s2_if.tkeep  = 2'b00;
    next_cycle();
    s2_if.tvalid = 1'b0;
    @(negedge clk);
    check("nokeep_tvalid", 32'(m2_if.tvalid), 32'd1);
    check("nokeep_tdata", 32'(m2_if.tdata), 32'hBEEF);
    check("nokeep_tkeep", 32'(m2_if.tkeep), 32'h3);

    // Randomised streaming against a queue model
    next_cycle();
    q.delete();
    cur       = '0;
    cur_valid = 1'b0;
    sent      = 0;
    dut_out   = 0;
    cyc       = 0;
    while (dut_out < 100 && cyc < 5000) begin
      if (!cur_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
        cur.data  = 8'(sent);
        cur.strb  = 1'($urandom);
        cur.keep  = 1'($urandom);
        cur.last  = ((sent % 8) == 7);
        cur.id    = 4'($urandom);
        cur.dest  = 3'($urandom);
        cur.user  = 2'($urandom);
        cur.wake  = 1'($urandom);
        cur_valid = 1'b1;
      end
      s_if.tvalid  = cur_valid;
      s_if.tdata   = cur.data;
      s_if.tstrb   = cur.strb;
      s_if.tkeep   = cur.keep;
      s_if.tlast   = cur.last;
      s_if.tid     = cur.id;
      s_if.tdest   = cur.dest;
      s_if.tuser   = cur.user;
      s_if.twakeup = cur.wake;
      // Alternate between a slow and a fast consumer so the FIFO both fills and drains.
      if (((cyc / 40) % 2) == 0) m_if.tready = ($urandom_range(0, 3) == 0);
      else                       m_if.tready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_valid = (q.size() != 0);
      exp_ready = (q.size() < Depth);
      check("rnd_count", 32'(count), 32'(q.size()));
      check("rnd_tvalid", 32'(m_if.tvalid), 32'(exp_valid));
      check("rnd_tready", 32'(s_if.tready), 32'(exp_ready));
      if (exp_valid) begin
        act = '{data: m_if.tdata, strb: m_if.tstrb, keep: m_if.tkeep, last: m_if.tlast,
                id: m_if.tid, dest: m_if.tdest, user: m_if.tuser, wake: m_if.twakeup};
        check("rnd_head", 32'(act), 32'(q[0]));
      end
      @(posedge clk);
      if (m_if.tvalid && m_if.tready) dut_out++;
      if (m_if.tready && exp_valid) void'(q.pop_front());
      if (cur_valid && exp_ready) begin
        q.push_back(cur);
        sent++;
        cur_valid = 1'b0;
      end
      #1;
      cyc++;
    end
    check("rnd_beats_out", 32'(dut_out), 32'd100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
